sync_join: RTL and testbench

//  Clocked two-input join, the converging counterpart of the PE copy/fork stage. It buffers
//  two independent valid/ready input channels and fires only when both hold a packet. It then

---
 rtl/sync_join_pkg.sv | 27 ++
 rtl/sync_join_fifo.sv | 49 ++++
 rtl/sync_join.sv | 103 ++++++++++
 tb/tb_sync_join.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_join_pkg.sv
// Shared channel types and sizing helpers for the join datapath.
// Provides: pkt_t, join_pkt_t {hi, lo}, clog2_min1(), PTR_W.
package chan_pkg;

    localparam int PKT_W = 4;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef struct packed {
        pkt_t hi;
        pkt_t lo;
    } join_pkt_t;

    // ceil(log2(n)), but never below 1 so a 1-entry index still has a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // pointer width for the default 2-entry FIFO (index bits + wrap bit)
    localparam int PTR_W = clog2_min1(2) + 1;

endpackage

// File: rtl/sync_join_fifo.sv
// Synchronous FIFO with wrap-bit pointers; one instance buffers each join input.
// Ports: clk, rst (sync, high), push/data in, pop in, full/empty/head out.
module sync_fifo
    import chan_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = clog2_min1(DEPTH);

    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    // full: same slot, opposite lap
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign head    = mem[rp[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= data;
    end

endmodule

// File: rtl/sync_join.sv
// Two-input join: pairs heads of two buffered channels into {l1,l0} through an FL-stage pipe.
// Ports: l0/l1 valid/ready/data in, r valid/ready/data out; clk, rst (sync, high).
module sync_join
    import chan_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 2,
    parameter int FL         = 2,
    parameter int INIT_TOKEN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   l0_data,
    input  logic               l0_valid,
    output logic               l0_ready,
    input  logic [WIDTH-1:0]   l1_data,
    input  logic               l1_valid,
    output logic               l1_ready,
    output logic [2*WIDTH-1:0] r_data,
    output logic               r_valid,
    input  logic               r_ready
);

    logic             full0;
    logic             empty0;
    logic             full1;
    logic             empty1;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic             fire;

    logic [FL:1]        v;
    logic [FL:1]        adv;
    logic [2*WIDTH-1:0] d [1:FL];

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (l0_valid),
        .data  (l0_data),
        .pop   (fire),
        .full  (full0),
        .empty (empty0),
        .head  (head0)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (l1_valid),
        .data  (l1_data),
        .pop   (fire),
        .full  (full1),
        .empty (empty1),
        .head  (head1)
    );

    // full flags come straight from pointer flops, so ready has no input path
    assign l0_ready = !full0;
    assign l1_ready = !full1;

    // advance chain, resolved from the output back toward stage 1
    always_comb begin
        adv     = '0;
        adv[FL] = v[FL] && r_ready;
        for (int k = FL - 1; k >= 1; k--) begin
            adv[k] = v[k] && (!v[k+1] || adv[k+1]);
        end
    end

    assign fire = !empty0 && !empty1 && (!v[1] || adv[1]);

    for (genvar k = 1; k <= FL; k++) begin : g_stage
        localparam logic RST_V = (k == FL) && (INIT_TOKEN != 0);

        logic               load;
        logic [2*WIDTH-1:0] nxt;

        if (k == 1) begin : g_first
            assign load = fire;
            assign nxt  = {head1, head0};
        end else begin : g_next
            assign load = adv[k-1];
            assign nxt  = d[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v[k] <= RST_V;
                d[k] <= '0;
            end else if (load) begin
                v[k] <= 1'b1;
                d[k] <= nxt;
            end else if (adv[k]) begin
                v[k] <= 1'b0;
            end
        end
    end

    assign r_valid = v[FL];
    assign r_data  = d[FL];

endmodule

// File: tb/tb_sync_join.sv
// Self-checking bench for sync_join: directed vectors plus randomized queue scoreboard.
// Drives inputs 1ns after rising edges and samples on falling edges.
module tb_sync_join;
    import chan_pkg::*;

    localparam int WIDTH      = 4;
    localparam int DEPTH      = 2;
    localparam int FL         = 2;
    localparam int INIT_TOKEN = 1;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] l0_data  = '0;
    logic [3:0] l1_data  = '0;
    logic       l0_valid = 1'b0;
    logic       l1_valid = 1'b0;
    logic       l0_ready;
    logic       l1_ready;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ready  = 1'b0;

    sync_join #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FL(FL), .INIT_TOKEN(INIT_TOKEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .l0_data  (l0_data),
        .l0_valid (l0_valid),
        .l0_ready (l0_ready),
        .l1_data  (l1_data),
        .l1_valid (l1_valid),
        .l1_ready (l1_ready),
        .r_data   (r_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pkt_t       q0[$];
    pkt_t       q1[$];
    logic [3:0] sa[$];
    logic [3:0] sb[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    join_pkt_t  jp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: per-channel arrival queues, paired in order into an expected output queue
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
            exp_q.delete();
            prev_stall = 1'b0;
            if (INIT_TOKEN != 0) exp_q.push_back(8'h00);
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(r_valid), 1);
                check("stall_data", 32'(r_data), 32'(prev_data));
            end
            if (r_valid && r_ready) begin
                obs_q.push_back(r_data);
                check("sb_beat_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sb_data", 32'(r_data), 32'(exp_q.pop_front()));
            end
            if (l0_valid && l0_ready) q0.push_back(l0_data);
            if (l1_valid && l1_ready) q1.push_back(l1_data);
            while (q0.size() > 0 && q1.size() > 0) begin
                jp.hi = q1.pop_front();
                jp.lo = q0.pop_front();
                exp_q.push_back(jp);
            end
            prev_stall = r_valid && !r_ready;
            prev_data  = r_data;
        end
    end

    // Offers sa/sb words on the two inputs, holding each until it is accepted
    task automatic stream(input int maxc);
        int   c;
        logic t0;
        logic t1;
        c = 0;
        while ((sa.size() > 0 || sb.size() > 0) && c < maxc) begin
            l0_valid = (sa.size() > 0);
            if (sa.size() > 0) l0_data = sa[0];
            l1_valid = (sb.size() > 0);
            if (sb.size() > 0) l1_data = sb[0];
            @(negedge clk);
            t0 = l0_valid && l0_ready;
            t1 = l1_valid && l1_ready;
            @(posedge clk);
            #1;
            if (t0) void'(sa.pop_front());
            if (t1) void'(sb.pop_front());
            c++;
        end
        l0_valid = (sa.size() > 0);
        l1_valid = (sb.size() > 0);
    endtask

    task automatic wait_beats(input int n, input int maxc, input string nm);
        int k;
        k = 0;
        while (obs_q.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(nm, obs_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] r;
    } vec_t;

    vec_t tv[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   c0;
        logic t0;
        logic t1;

        tv[0] = '{4'h3, 4'hA, 8'hA3};
        tv[1] = '{4'hF, 4'h0, 8'h0F};
        tv[2] = '{4'h0, 4'hF, 8'hF0};
        tv[3] = '{4'h5, 4'h5, 8'h55};

        // 1: reset state and init token held under backpressure
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        check("rst_l0_ready", 32'(l0_ready), 1);
        check("rst_l1_ready", 32'(l1_ready), 1);
        check("rst_r_valid", 32'(r_valid), 32'(INIT_TOKEN));
        check("rst_r_data", 32'(r_data), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("init_hold", {r_valid, r_data}, 32'h100);
        end
        @(posedge clk);
        #1;
        r_ready = 1'b1;
        @(negedge clk);
        check("init_beat", 32'(r_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("init_gone", 32'(r_valid), 0);
        check("init_count", obs_q.size(), 1);

        // 2: single pairs, latency and single emission
        foreach (tv[i]) begin
            @(posedge clk);
            #1;
            l0_valid = 1'b1;
            l0_data  = tv[i].a;
            l1_valid = 1'b1;
            l1_data  = tv[i].b;
            lat = 0;
            while (lat < 10) begin
                @(posedge clk);
                #1;
                if (lat == 0) begin
                    l0_valid = 1'b0;
                    l1_valid = 1'b0;
                end
                lat++;
                if (r_valid) break;
            end
            check("vec_latency", lat, FL + 1);
            check("vec_data", 32'(r_data), 32'(tv[i].r));
            @(posedge clk);
            #1;
            check("vec_once", 32'(r_valid), 0);
        end

        // 3: one side alone fills and stalls, then pairs in order
        obs_q.delete();
        sa = '{4'h1, 4'h2, 4'h3};
        sb.delete();
        stream(6);
        check("lone_left", sa.size(), 1);
        check("lone_ready", 32'(l0_ready), 0);
        check("lone_no_out", 32'(r_valid), 0);
        sb = '{4'h4, 4'h5, 4'h6};
        stream(40);
        wait_beats(3, 30, "lone_beats");
        if (obs_q.size() >= 3) begin
            check("lone_b0", 32'(obs_q[0]), 32'h41);
            check("lone_b1", 32'(obs_q[1]), 32'h52);
            check("lone_b2", 32'(obs_q[2]), 32'h63);
        end

        // 4: full backpressure, then release at full rate
        obs_q.delete();
        r_ready = 1'b0;
        sa.delete();
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            sa.push_back(4'(i));
            sb.push_back(4'(15 - i));
        end
        stream(20);
        check("bp_left0", sa.size(), 16 - DEPTH - FL);
        check("bp_left1", sb.size(), 16 - DEPTH - FL);
        check("bp_ready", {l0_ready, l1_ready}, 0);
        check("bp_valid", 32'(r_valid), 1);
        check("bp_no_out", obs_q.size(), 0);
        r_ready = 1'b1;
        c0 = cyc;
        stream(60);
        wait_beats(16, 60, "bp_beats");
        check("bp_rate", 32'((cyc - c0) <= 16 + FL + 6), 1);
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            check("bp_pair", 32'(obs_q[i]), 32'({4'(15 - i), 4'(i)}));
        end

        // 5: random traffic against the scoreboard
        t0 = 1'b0;
        t1 = 1'b0;
        l0_valid = 1'b0;
        l1_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!l0_valid || t0) begin
                l0_valid = 1'($urandom_range(0, 1));
                l0_data  = 4'($urandom);
            end
            if (!l1_valid || t1) begin
                l1_valid = 1'($urandom_range(0, 1));
                l1_data  = 4'($urandom);
            end
            r_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            t0 = l0_valid && l0_ready;
            t1 = l1_valid && l1_ready;
            @(posedge clk);
            #1;
        end
        l0_valid = 1'b0;
        l1_valid = 1'b0;
        r_ready  = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("rand_drained", exp_q.size(), 0);

        // 6: reset with packets in flight
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        sa = '{4'h1, 4'h2, 4'h3};
        sb = '{4'h9, 4'hA, 4'hB};
        stream(8);
        l0_valid = 1'b0;
        l1_valid = 1'b0;
        sa.delete();
        sb.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        check("mid_rst_l0_ready", 32'(l0_ready), 1);
        check("mid_rst_l1_ready", 32'(l1_ready), 1);
        check("mid_rst_out", {r_valid, r_data}, 32'h100);
        r_ready = 1'b1;
        sa = '{4'h7};
        sb = '{4'h8};
        stream(10);
        wait_beats(2, 20, "mid_rst_beats");
        if (obs_q.size() >= 2) begin
            check("mid_rst_tok", 32'(obs_q[0]), 0);
            check("mid_rst_pair", 32'(obs_q[1]), 32'h87);
        end
        repeat (6) @(posedge clk);
        check("mid_rst_no_stale", obs_q.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
